// File: rtl/lemming_pkg.sv
// ============================================================================
// lemming_pkg : shared state encoding and terrain geometry for lemming_world
// Revision    : 1.0
// ============================================================================
`default_nettype none

package lemming_pkg;

  localparam int COLS  = 16;
  localparam int COL_W = $clog2(COLS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lemming_terrain.sv
// ============================================================================
// lemming_terrain : floor bitmap with load, clear-one and refill-all updates
// Revision        : 1.0
// ============================================================================
`default_nettype none

module lemming_terrain #(
  parameter int COLS  = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             load_i,
  input  logic [COLS-1:0]  load_val_i,
  input  logic             fill_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_bit_o
);

  logic [COLS-1:0] floor_q;
  logic [COLS-1:0] floor_d;

  always_comb begin
    floor_d = floor_q;
    if (load_i) begin
      floor_d = load_val_i;
    end else if (fill_i) begin
      floor_d = '1;
    end else if (clr_i) begin
      floor_d[clr_idx_i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      floor_q <= '1;
    end else begin
      floor_q <= floor_d;
    end
  end

  assign rd_bit_o = floor_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/lemming_world.sv
// ============================================================================
// lemming_world : terrain/physics around a lemming FSM (walk, fall, dig, bump)
// Optional protocol checker output err enabled by LEMMING_WORLD_CHECK_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module lemming_world #(
  parameter int COLS     = 16,
  parameter int FALL_LEN = 3,
  parameter int DIG_LEN  = 2
) (
  input  logic                          clk,
  input  logic                          areset_n,
  input  logic                          map_load,
  input  logic [COLS-1:0]               map_floor,
  input  logic [lemming_pkg::COL_W-1:0] start_col,
  input  logic                          walk_left,
  input  logic                          walk_right,
  input  logic                          aaah,
  input  logic                          digging,
  output logic                          ground,
  output logic                          bump_left,
  output logic                          bump_right,
  output logic [lemming_pkg::COL_W-1:0] col,
  output logic [3:0]                    depth
`ifdef LEMMING_WORLD_CHECK_EN
  ,
  output logic                          err
`endif
);

  import lemming_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [3:0]       FALL_M1  = 4'(FALL_LEN - 1);
  localparam logic [3:0]       DIG_M1   = 4'(DIG_LEN - 1);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [3:0]       depth_q, depth_d;
  logic [3:0]       fall_q, fall_d;
  logic [3:0]       dig_q, dig_d;

  logic run;
  logic floor_bit;
  logic fill;
  logic clr;

  assign run = (state_q == ST_RUN);

  lemming_terrain #(
    .COLS  (COLS),
    .IDX_W (COL_W)
  ) u_terrain (
    .clk        (clk),
    .areset_n   (areset_n),
    .load_i     (map_load),
    .load_val_i (map_floor),
    .fill_i     (fill),
    .clr_i      (clr),
    .clr_idx_i  (col_q),
    .rd_idx_i   (col_q),
    .rd_bit_o   (floor_bit)
  );

  assign ground     = run ? floor_bit : 1'b1;
  assign bump_left  = run & walk_left  & (col_q == '0);
  assign bump_right = run & walk_right & (col_q == LAST_COL);
  assign col        = col_q;
  assign depth      = depth_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    depth_d = depth_q;
    fall_d  = fall_q;
    dig_d   = dig_q;
    fill    = 1'b0;
    clr     = 1'b0;
    if (map_load) begin
      state_d = ST_RUN;
      col_d   = start_col;
      depth_d = 4'd0;
      fall_d  = 4'd0;
      dig_d   = 4'd0;
    end else if (run) begin
      if (!floor_bit) begin
        // Falling: the last low cycle lands on a fresh, fully solid level.
        dig_d = 4'd0;
        if (fall_q == FALL_M1) begin
          fill   = 1'b1;
          fall_d = 4'd0;
          if (depth_q != 4'hF) begin
            depth_d = depth_q + 4'd1;
          end
        end else begin
          fall_d = fall_q + 4'd1;
        end
      end else if (digging) begin
        if (dig_q == DIG_M1) begin
          clr   = 1'b1;
          dig_d = 4'd0;
        end else begin
          dig_d = dig_q + 4'd1;
        end
      end else begin
        dig_d = 4'd0;
        if (walk_left && !walk_right && col_q != '0) begin
          col_d = col_q - 1'b1;
        end else if (walk_right && !walk_left && col_q != LAST_COL) begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      depth_q <= 4'd0;
      fall_q  <= 4'd0;
      dig_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      depth_q <= depth_d;
      fall_q  <= fall_d;
      dig_q   <= dig_d;
    end
  end

`ifdef LEMMING_WORLD_CHECK_EN
  logic err_q;
  logic ground_prev_q;
  logic multi_hot;

  assign multi_hot = (walk_left  & walk_right) | (walk_left  & aaah) |
                     (walk_left  & digging)    | (walk_right & aaah) |
                     (walk_right & digging)    | (aaah       & digging);

  // ground_prev_q tracks ground on the previous RUN cycle to detect a false aaah.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      err_q         <= 1'b0;
      ground_prev_q <= 1'b0;
    end else if (map_load) begin
      err_q         <= 1'b0;
      ground_prev_q <= 1'b0;
    end else if (run) begin
      if (multi_hot || (aaah && ground && ground_prev_q)) begin
        err_q <= 1'b1;
      end
      ground_prev_q <= ground;
    end
  end

  assign err = err_q;
`else
  logic unused_aaah;
  assign unused_aaah = aaah;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lemming_world.sv
// ============================================================================
// tb_lemming_world : directed vector table, corner sequences and random model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_lemming_world;

  localparam int FALL_LEN = 3;
  localparam int DIG_LEN  = 2;

  logic        clk = 1'b0;
  logic        areset_n;
  logic        map_load;
  logic [15:0] map_floor;
  logic [3:0]  start_col;
  logic        walk_left, walk_right, aaah, digging;
  logic        ground, bump_left, bump_right;
  logic [3:0]  col;
  logic [3:0]  depth;
`ifdef LEMMING_WORLD_CHECK_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  lemming_world #(
    .COLS     (16),
    .FALL_LEN (FALL_LEN),
    .DIG_LEN  (DIG_LEN)
  ) dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .map_load   (map_load),
    .map_floor  (map_floor),
    .start_col  (start_col),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .ground     (ground),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .col        (col),
    .depth      (depth)
`ifdef LEMMING_WORLD_CHECK_EN
    ,
    .err        (err)
`endif
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input bit ld, input logic [15:0] f, input logic [3:0] sc,
                       input bit wl, input bit wr, input bit aa, input bit dg);
    map_load   = ld;
    map_floor  = f;
    start_col  = sc;
    walk_left  = wl;
    walk_right = wr;
    aaah       = aa;
    digging    = dg;
  endtask

  // Vector table: inputs for one cycle and the outputs expected during it.
  typedef struct {
    bit          ld;
    logic [15:0] f;
    logic [3:0]  sc;
    bit          wl, wr, aa, dg;
    bit          chk_en;
    bit          eg;
    int          ecol, edep;
    bit          ebl, ebr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit ld, input logic [15:0] f, input logic [3:0] sc,
                     input bit wl, input bit wr, input bit dg, input bit c,
                     input bit eg, input int ecol, input int edep,
                     input bit ebl, input bit ebr);
    vec_t v;
    v.ld = ld; v.f = f; v.sc = sc; v.wl = wl; v.wr = wr; v.aa = 1'b0; v.dg = dg;
    v.chk_en = c; v.eg = eg; v.ecol = ecol; v.edep = edep; v.ebl = ebl; v.ebr = ebr;
    tbl.push_back(v);
  endtask

  // Behavioural reference model
  bit        m_run;
  bit [15:0] m_floor;
  int        m_col, m_depth, m_fall, m_dig;
`ifdef LEMMING_WORLD_CHECK_EN
  bit        m_err, m_gprev;
`endif

  task automatic model_reset();
    m_run = 0; m_floor = '1; m_col = 0; m_depth = 0; m_fall = 0; m_dig = 0;
`ifdef LEMMING_WORLD_CHECK_EN
    m_err = 0; m_gprev = 0;
`endif
  endtask

  task automatic model_step(input bit ld, input bit [15:0] f, input int sc,
                            input bit wl, input bit wr, input bit aa, input bit dg);
    bit g;
    if (ld) begin
      m_run = 1; m_floor = f; m_col = sc; m_depth = 0; m_fall = 0; m_dig = 0;
`ifdef LEMMING_WORLD_CHECK_EN
      m_err = 0; m_gprev = 0;
`endif
    end else if (m_run) begin
      g = m_floor[m_col];
`ifdef LEMMING_WORLD_CHECK_EN
      if ((int'(wl) + int'(wr) + int'(aa) + int'(dg)) > 1 || (aa && g && m_gprev)) m_err = 1;
      m_gprev = g;
`endif
      if (!g) begin
        m_dig = 0;
        if (m_fall == FALL_LEN - 1) begin
          m_floor = '1;
          m_fall  = 0;
          if (m_depth < 15) m_depth++;
        end else begin
          m_fall++;
        end
      end else if (dg) begin
        if (m_dig == DIG_LEN - 1) begin
          m_floor[m_col] = 1'b0;
          m_dig = 0;
        end else begin
          m_dig++;
        end
      end else begin
        m_dig = 0;
        if (wl && !wr && m_col > 0) m_col--;
        else if (wr && !wl && m_col < 15) m_col++;
      end
    end
  endtask

  initial begin
    areset_n = 1'b0;
    drive(0, 16'h0, 4'h0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_ground", int'(ground), 1);
    chk("reset_col", int'(col), 0);
    chk("reset_depth", int'(depth), 0);
    areset_n = 1'b1;

    // IDLE ignores inputs
    add(0, 16'h0000, 4'h0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    // Left wall bump
    add(1, 16'hFFFF, 4'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 16'h0000, 4'd0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
    // Walk right three steps
    add(1, 16'hFFFF, 4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 1, 5, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 1, 6, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 1, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
    // Right wall bump, including both-walk at the wall
    add(1, 16'hFFFF, 4'd15, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 1, 15, 0, 0, 1);
    add(0, 16'h0000, 4'd0, 1, 1, 0, 1, 1, 15, 0, 0, 1);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 15, 0, 0, 0);
    // Both walks mid-field hold position
    add(1, 16'hFFFF, 4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 1, 1, 0, 1, 1, 3, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
    // Walk into hole at column 5
    add(1, 16'hFFDF, 4'd4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 1, 4, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 0, 5, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 0, 5, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 1, 0, 1, 0, 5, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 5, 1, 0, 0);
    // Dig through at column 7
    add(1, 16'hFFFF, 4'd7, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 7, 1, 0, 0);
    // Interrupted dig restarts its count
    add(1, 16'hFFFF, 4'd9, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 1, 1, 1, 9, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 9, 0, 0, 0);
    // map_load wins over an active fall
    add(1, 16'hFFDF, 4'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 0, 5, 0, 0, 0);
    add(1, 16'hFFFF, 4'd2, 0, 0, 0, 1, 0, 5, 0, 0, 0);
    add(0, 16'h0000, 4'd0, 0, 0, 0, 1, 1, 2, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ld, tbl[i].f, tbl[i].sc, tbl[i].wl, tbl[i].wr, tbl[i].aa, tbl[i].dg);
      #1;
      if (tbl[i].chk_en) begin
        chk($sformatf("row%0d_ground", i), int'(ground), int'(tbl[i].eg));
        chk($sformatf("row%0d_col", i), int'(col), tbl[i].ecol);
        chk($sformatf("row%0d_depth", i), int'(depth), tbl[i].edep);
        chk($sformatf("row%0d_bump_left", i), int'(bump_left), int'(tbl[i].ebl));
        chk($sformatf("row%0d_bump_right", i), int'(bump_right), int'(tbl[i].ebr));
      end
    end

    // Depth saturates at 15 after repeated dig-and-fall
    @(negedge clk); drive(1, 16'hFFFF, 4'd0, 0, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      repeat (2) begin @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 1); end
      repeat (3) begin @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); end
      if (k == 13) begin
        @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
        chk("depth_14", int'(depth), 14);
      end
    end
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
    chk("depth_sat", int'(depth), 15);
    chk("depth_sat_ground", int'(ground), 1);

    // Asynchronous reset mid-fall, then idle until map_load
    @(negedge clk); drive(1, 16'hFFDF, 4'd5, 0, 0, 0, 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
    chk("midfall_pre0", int'(ground), 0);
    @(negedge clk); #1;
    chk("midfall_pre1", int'(ground), 0);
    areset_n = 1'b0; #1;
    chk("async_rst_ground", int'(ground), 1);
    chk("async_rst_col", int'(col), 0);
    chk("async_rst_depth", int'(depth), 0);
    @(negedge clk); areset_n = 1'b1;
    drive(0, 16'h0000, 4'd9, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_idle_col", int'(col), 0);
    chk("post_rst_idle_ground", int'(ground), 1);
    chk("post_rst_idle_bump", int'(bump_right), 0);
    @(negedge clk); drive(1, 16'hFFFF, 4'd6, 0, 0, 0, 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
    chk("post_rst_load_col", int'(col), 6);

`ifdef LEMMING_WORLD_CHECK_EN
    @(negedge clk); drive(1, 16'hFFFF, 4'd4, 0, 0, 0, 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 1, 1, 0, 0); #1;
    chk("err_before", int'(err), 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
    chk("err_set", int'(err), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("err_sticky", int'(err), 1);
    @(negedge clk); drive(1, 16'hFFFF, 4'd4, 0, 0, 0, 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 1, 0); #1;
    chk("err_cleared", int'(err), 0);
    @(negedge clk); #1;
    chk("err_aaah_first", int'(err), 0);
    @(negedge clk); drive(0, 16'h0, 4'd0, 0, 0, 0, 0); #1;
    chk("err_aaah_second", int'(err), 1);
`endif

    // Randomized run against the reference model
    @(negedge clk); areset_n = 1'b0; drive(0, 16'h0, 4'd0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); areset_n = 1'b1;
    for (int n = 0; n < 800; n++) begin
      bit ld, wl, wr, aa, dg;
      bit [15:0] f;
      bit [3:0] sc;
      int r;
      bit eg;
      @(negedge clk);
      ld = ($urandom_range(0, 24) == 0);
      f  = 16'($urandom) | 16'($urandom);
      sc = 4'($urandom_range(0, 15));
      r  = $urandom_range(0, 7);
      wl = (r == 2); wr = (r == 3); aa = (r == 4); dg = (r == 5 || r == 6);
      if (r == 7) begin
        wl = 1'($urandom); wr = 1'($urandom); aa = 1'($urandom); dg = 1'($urandom);
      end
      drive(ld, f, sc, wl, wr, aa, dg);
      #1;
      eg = m_run ? m_floor[m_col] : 1'b1;
      chk($sformatf("rnd%0d_ground", n), int'(ground), int'(eg));
      chk($sformatf("rnd%0d_col", n), int'(col), m_col);
      chk($sformatf("rnd%0d_depth", n), int'(depth), m_depth);
      chk($sformatf("rnd%0d_bump_left", n), int'(bump_left), int'(m_run && wl && m_col == 0));
      chk($sformatf("rnd%0d_bump_right", n), int'(bump_right), int'(m_run && wr && m_col == 15));
`ifdef LEMMING_WORLD_CHECK_EN
      chk($sformatf("rnd%0d_err", n), int'(err), int'(m_err));
`endif
      @(posedge clk);
      model_step(ld, f, int'(sc), wl, wr, aa, dg);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
